// File: rtl/muldiv_pkg.sv
// Shared encodings for the EXE-stage multiply/divide sequencing controller.
package muldiv_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam int MUL_LAT_DEF = 2;
    localparam int DIV_W_DEF   = 40;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MUL_WAIT  = 3'd1,
        ST_DIV_ISSUE = 3'd2,
        ST_DIV_WAIT  = 3'd3,
        ST_DIV_DRAIN = 3'd4,
        ST_DONE      = 3'd5
    } state_e;

endpackage

// File: rtl/muldiv_ctrl.sv
// Sequences one MULT/MULTU/DIV/DIVU at a time onto the shared multiplier and
// AXI-stream divider, returning HI/LO through a valid/ready handshake.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_W   = DIV_W_DEF
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [31:0]          req_a,
    input  logic [31:0]          req_b,
    input  logic                 flush,
    output logic                 busy,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [31:0]          res_hi,
    output logic [31:0]          res_lo,
    output logic [32:0]          mul_a,
    output logic [32:0]          mul_b,
    input  logic [65:0]          mul_p,
    output logic [DIV_W-1:0]     div_dividend,
    output logic [DIV_W-1:0]     div_divisor,
    output logic                 div_in_valid,
    input  logic                 div_in_ready,
    input  logic [2*DIV_W-1:0]   div_out,
    input  logic                 div_out_valid
);

    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT - 1);

    state_e            state_q, state_d;
    logic              uns_q, uns_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       res_hi_q, res_hi_d;
    logic [31:0]       res_lo_q, res_lo_d;
    logic              res_valid_q, res_valid_d;
    logic              div_in_valid_q, div_in_valid_d;

    logic              ext_a, ext_b;
    logic [31:0]       quotient, remainder;
    logic              unused_bits;

    assign ext_a = ~uns_q & a_q[31];
    assign ext_b = ~uns_q & b_q[31];

    assign mul_a        = {ext_a, a_q};
    assign mul_b        = {ext_b, b_q};
    assign div_dividend = {{(DIV_W-32){ext_a}}, a_q};
    assign div_divisor  = {{(DIV_W-32){ext_b}}, b_q};

    assign quotient  = div_out[DIV_W +: 32];
    assign remainder = div_out[0 +: 32];
    assign unused_bits = ^{mul_p[65:64], div_out[2*DIV_W-1:DIV_W+32], div_out[DIV_W-1:32]};

    assign req_ready    = (state_q == ST_IDLE) & ~flush;
    assign busy         = (state_q != ST_IDLE);
    assign res_valid    = res_valid_q;
    assign res_hi       = res_hi_q;
    assign res_lo       = res_lo_q;
    assign div_in_valid = div_in_valid_q;

    always_comb begin
        state_d        = state_q;
        uns_d          = uns_q;
        a_d            = a_q;
        b_d            = b_q;
        cnt_d          = cnt_q;
        res_hi_d       = res_hi_q;
        res_lo_d       = res_lo_q;
        res_valid_d    = res_valid_q;
        div_in_valid_d = div_in_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    uns_d = req_op[0];
                    a_d   = req_a;
                    b_d   = req_b;
                    cnt_d = '0;
                    if (!req_op[1]) begin
                        state_d = ST_MUL_WAIT;
                    end else if (req_b == 32'd0) begin
                        // Divide by zero never touches the divider
                        state_d     = ST_DONE;
                        res_hi_d    = req_a;
                        res_lo_d    = 32'hFFFF_FFFF;
                        res_valid_d = 1'b1;
                    end else begin
                        state_d        = ST_DIV_ISSUE;
                        div_in_valid_d = 1'b1;
                    end
                end
            end
            ST_MUL_WAIT: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = ST_DONE;
                    res_hi_d    = mul_p[63:32];
                    res_lo_d    = mul_p[31:0];
                    res_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DIV_ISSUE: begin
                if (flush) begin
                    // An operand already handed over must still be drained
                    div_in_valid_d = 1'b0;
                    state_d        = div_in_ready ? ST_DIV_DRAIN : ST_IDLE;
                end else if (div_in_ready) begin
                    div_in_valid_d = 1'b0;
                    state_d        = ST_DIV_WAIT;
                end
            end
            ST_DIV_WAIT: begin
                if (flush) begin
                    state_d = div_out_valid ? ST_IDLE : ST_DIV_DRAIN;
                end else if (div_out_valid) begin
                    state_d     = ST_DONE;
                    res_lo_d    = quotient;
                    res_hi_d    = remainder;
                    res_valid_d = 1'b1;
                end
            end
            ST_DIV_DRAIN: begin
                if (div_out_valid) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (flush || res_ready) begin
                    state_d     = ST_IDLE;
                    res_valid_d = 1'b0;
                end
            end
            default: begin
                state_d        = ST_IDLE;
                res_valid_d    = 1'b0;
                div_in_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            uns_q          <= 1'b0;
            a_q            <= '0;
            b_q            <= '0;
            cnt_q          <= '0;
            res_hi_q       <= '0;
            res_lo_q       <= '0;
            res_valid_q    <= 1'b0;
            div_in_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            uns_q          <= uns_d;
            a_q            <= a_d;
            b_q            <= b_d;
            cnt_q          <= cnt_d;
            res_hi_q       <= res_hi_d;
            res_lo_q       <= res_lo_d;
            res_valid_q    <= res_valid_d;
            div_in_valid_q <= div_in_valid_d;
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomised and directed bench for muldiv_ctrl with behavioural multiplier,
// divider and HI/LO reference models.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    localparam int MUL_LAT = 2;
    localparam int DW      = DIV_W_DEF;

    logic              clk;
    logic              resetn;
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [31:0]       req_a;
    logic [31:0]       req_b;
    logic              flush;
    logic              busy;
    logic              res_valid;
    logic              res_ready;
    logic [31:0]       res_hi;
    logic [31:0]       res_lo;
    logic [32:0]       mul_a;
    logic [32:0]       mul_b;
    logic [65:0]       mul_p;
    logic [DW-1:0]     div_dividend;
    logic [DW-1:0]     div_divisor;
    logic              div_in_valid;
    logic              div_in_ready;
    logic [2*DW-1:0]   div_out;
    logic              div_out_valid;

    int checks = 0;
    int errors = 0;

    // divider environment state
    int              div_lat   = 3;
    int              rdy_delay = 0;
    bit              dpend     = 0;
    int              dcnt      = 0;
    int              vcnt      = 0;
    logic [2*DW-1:0] dres      = '0;

    muldiv_ctrl #(.MUL_LAT(MUL_LAT), .DIV_W(DW)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .flush(flush), .busy(busy),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_hi(res_hi), .res_lo(res_lo),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_in_valid(div_in_valid), .div_in_ready(div_in_ready),
        .div_out(div_out), .div_out_valid(div_out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier: signed 33x33 product
    assign mul_p = 66'($signed(mul_a)) * 66'($signed(mul_b));

    // One clock: advance, then update the divider model and its tready
    task automatic tick();
        logic hs;
        logic signed [DW-1:0] dd, ds, q, r;
        hs = div_in_valid && div_in_ready;
        dd = div_dividend;
        ds = div_divisor;
        @(posedge clk);
        #1;
        div_out_valid = 1'b0;
        if (hs) begin
            dpend = 1;
            dcnt  = div_lat;
            if (ds != 0) begin
                q = dd / ds;
                r = dd % ds;
            end else begin
                q = '1;
                r = '1;
            end
            dres = {q, r};
        end else if (dpend) begin
            dcnt--;
            if (dcnt <= 0) begin
                div_out       = dres;
                div_out_valid = 1'b1;
                dpend         = 0;
            end
        end
        vcnt = div_in_valid ? vcnt + 1 : 0;
        div_in_ready = div_in_valid && (vcnt > rdy_delay);
    endtask

    // Issue one op, wait for result, hold res_ready low 'hold' cycles, consume
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold);
        longint sa, sb, p, q, r;
        logic [31:0] ehi, elo, hi0, lo0;
        logic [DW-1:0] dd0, ds0;
        int c, vcyc;
        bit stable;
        if (op[0]) begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end
        if (!op[1]) begin
            p = sa * sb;
            ehi = p[63:32];
            elo = p[31:0];
        end else if (b == 32'd0) begin
            ehi = a;
            elo = 32'hFFFF_FFFF;
        end else begin
            q = sa / sb;
            r = sa % sb;
            elo = q[31:0];
            ehi = r[31:0];
        end

        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready: req_ready=%b expected 1", req_ready);
        end
        tick();
        req_valid = 1'b0;
        req_a     = $urandom;
        req_b     = $urandom;
        req_op    = 2'($urandom);

        c = 1;
        vcyc = 0;
        stable = 1;
        dd0 = div_dividend;
        ds0 = div_divisor;
        while (!res_valid && c < 300) begin
            if (div_in_valid) begin
                vcyc++;
                if (div_dividend !== dd0 || div_divisor !== ds0) stable = 0;
            end
            tick();
            c++;
        end
        checks++;
        if (res_valid !== 1'b1) begin
            errors++;
            $display("FAIL result_timeout: res_valid=%b after %0d cycles expected 1", res_valid, c);
        end
        if (!op[1] || b == 32'd0) begin
            checks++;
            if (c != ((!op[1]) ? MUL_LAT + 1 : 1) || vcyc != 0) begin
                errors++;
                $display("FAIL latency: op=%0d lat=%0d div_in_cycles=%0d expected lat=%0d div_in_cycles=0",
                         op, c, vcyc, (!op[1]) ? MUL_LAT + 1 : 1);
            end
        end else begin
            checks++;
            if (vcyc != rdy_delay + 1 || !stable) begin
                errors++;
                $display("FAIL div_issue: valid_cycles=%0d stable=%0d expected valid_cycles=%0d stable=1",
                         vcyc, stable, rdy_delay + 1);
            end
        end
        checks++;
        if (res_hi !== ehi || res_lo !== elo) begin
            errors++;
            $display("FAIL result: op=%0d a=%h b=%h hi=%h lo=%h expected hi=%h lo=%h",
                     op, a, b, res_hi, res_lo, ehi, elo);
        end
        hi0 = res_hi;
        lo0 = res_lo;
        for (int i = 0; i < hold; i++) begin
            res_ready = 1'b0;
            tick();
            checks++;
            if (res_valid !== 1'b1 || res_hi !== hi0 || res_lo !== lo0 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL done_hold: valid=%b hi=%h lo=%h req_ready=%b expected valid=1 hi=%h lo=%h req_ready=0",
                         res_valid, res_hi, res_lo, req_ready, hi0, lo0);
            end
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL consume: valid=%b busy=%b req_ready=%b expected 0 0 1",
                     res_valid, busy, req_ready);
        end
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h lat=%0d hold=%0d", op, a, b, hi0, lo0, c, hold);
    endtask

    task automatic test_reset();
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || div_in_valid !== 1'b0 || res_hi !== 32'd0 ||
            res_lo !== 32'd0 || mul_a !== 33'd0 || mul_b !== 33'd0 || div_dividend !== '0 ||
            div_divisor !== '0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: busy=%b rv=%b dv=%b hi=%h lo=%h ma=%h rr=%b expected all 0, rr=1",
                     busy, res_valid, div_in_valid, res_hi, res_lo, mul_a, req_ready);
        end
        flush = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_flush_ready: req_ready=%b expected 0", req_ready);
        end
        flush = 1'b0;
        #1;
        $display("reset state checked");
    endtask

    task automatic test_directed();
        rdy_delay = 0;
        div_lat   = 3;
        do_op(MD_MULT,  32'hFFFF_FFFF, 32'h2, 0);
        do_op(MD_MULTU, 32'hFFFF_FFFF, 32'h2, 0);
        rdy_delay = 3;
        do_op(MD_DIV,   32'hFFFF_FFF9, 32'h2, 0);
        rdy_delay = 0;
        do_op(MD_DIVU,  32'h7, 32'h2, 0);
        do_op(MD_DIVU,  32'h1234, 32'h0, 0);
        do_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op(MD_MULT,  32'h1234_5678, 32'h9ABC_DEF0, 5);
    endtask

    task automatic test_flush_div_wait();
        int n;
        div_lat   = 7;
        rdy_delay = 0;
        req_valid = 1'b1; req_op = MD_DIVU; req_a = 32'd100; req_b = 32'd7;
        tick();
        req_valid = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n = 0;
        while (!div_out_valid && n < 50) begin
            checks++;
            if (busy !== 1'b1 || res_valid !== 1'b0) begin
                errors++;
                $display("FAIL drain_busy: busy=%b res_valid=%b expected 1 0", busy, res_valid);
            end
            tick();
            n++;
        end
        checks++;
        if (div_out_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL drain_arrive: dout_valid=%b busy=%b after %0d expected 1 1", div_out_valid, busy, n);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL drain_exit: busy=%b rv=%b req_ready=%b expected 0 0 1", busy, res_valid, req_ready);
        end
        $display("flush in DIV_WAIT drained after %0d cycles", n);
        div_lat = 3;
        do_op(MD_MULTU, 32'd3, 32'd5, 0);
    endtask

    task automatic test_flush_other();
        int n;
        // flush during MUL_WAIT
        req_valid = 1'b1; req_op = MD_MULT; req_a = 32'd9; req_b = 32'd9;
        tick();
        req_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_mul: busy=%b rv=%b expected 0 0", busy, res_valid);
        end
        // flush during DONE
        req_valid = 1'b1; req_op = MD_DIV; req_a = 32'd5; req_b = 32'd0;
        tick();
        req_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_done: busy=%b rv=%b expected 0 0", busy, res_valid);
        end
        // flush during DIV_ISSUE with no handshake
        rdy_delay = 5;
        req_valid = 1'b1; req_op = MD_DIV; req_a = 32'd50; req_b = 32'd3;
        tick();
        req_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || div_in_valid !== 1'b0 || dpend) begin
            errors++;
            $display("FAIL flush_issue: busy=%b div_in_valid=%b issued=%0d expected 0 0 0",
                     busy, div_in_valid, dpend);
        end
        // flush during DIV_ISSUE coinciding with the handshake
        rdy_delay = 0;
        div_lat   = 2;
        req_valid = 1'b1; req_op = MD_DIV; req_a = 32'd50; req_b = 32'd3;
        tick();
        req_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (busy !== 1'b1 || div_in_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_issue_hs: busy=%b div_in_valid=%b expected 1 0", busy, div_in_valid);
        end
        n = 0;
        while (!div_out_valid && n < 20) begin
            tick();
            n++;
        end
        tick();
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_issue_drain: busy=%b rv=%b expected 0 0", busy, res_valid);
        end
        div_lat = 3;
        $display("flush in MUL_WAIT, DONE, DIV_ISSUE checked");
    endtask

    task automatic test_async_reset();
        req_valid = 1'b1; req_op = MD_MULT; req_a = 32'h8000_0001; req_b = 32'hC000_0003;
        tick();
        req_valid = 1'b0;
        #3;
        resetn = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || div_in_valid !== 1'b0 || res_hi !== 32'd0 ||
            res_lo !== 32'd0 || mul_a !== 33'd0 || mul_b !== 33'd0 || div_dividend !== '0 ||
            div_divisor !== '0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: busy=%b rv=%b hi=%h lo=%h ma=%h mb=%h rr=%b expected zeros, rr=1",
                     busy, res_valid, res_hi, res_lo, mul_a, mul_b, req_ready);
        end
        tick();
        resetn = 1'b1;
        tick();
        div_out       = {DW{2'b10}};
        div_out_valid = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || res_hi !== 32'd0 || res_lo !== 32'd0) begin
            errors++;
            $display("FAIL stray_dout: busy=%b rv=%b hi=%h lo=%h expected 0 0 0 0",
                     busy, res_valid, res_hi, res_lo);
        end
        $display("async reset mid MUL_WAIT and stray divider result checked");
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op        = 2'($urandom);
            a         = $urandom;
            b         = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
            div_lat   = $urandom_range(1, 6);
            rdy_delay = $urandom_range(0, 3);
            do_op(op, a, b, $urandom_range(0, 3));
        end
    endtask

    initial begin
        resetn        = 1'b0;
        req_valid     = 1'b0;
        req_op        = 2'b00;
        req_a         = 32'd0;
        req_b         = 32'd0;
        flush         = 1'b0;
        res_ready     = 1'b0;
        div_in_ready  = 1'b0;
        div_out       = '0;
        div_out_valid = 1'b0;
        #2;
        test_reset();
        tick();
        tick();
        resetn = 1'b1;
        tick();
        test_directed();
        test_flush_div_wait();
        test_flush_other();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
